// File: rtl/ula_op_sequencer_pkg.sv
// Shared opcodes, FSM encoding and latency lookup for the ULA op sequencer.
// Optional Zero flag is enabled by defining ULA_ZERO_FLAG_EN.
package ula_pkg;

  localparam logic [2:0] OP_NOTUSE = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_MUL    = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_AND    = 3'd5;
  localparam logic [2:0] OP_OR     = 3'd6;
  localparam logic [2:0] OP_XOR    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // NotUse has no settle time; it never reaches EXEC, so 1 keeps the load value legal.
  function automatic int op_latency(input logic [2:0] op, input int add_lat,
                                    input int mul_lat, input int div_lat,
                                    input int log_lat);
    case (op)
      OP_ADD, OP_SUB:        op_latency = add_lat;
      OP_MUL:                op_latency = mul_lat;
      OP_DIV:                op_latency = div_lat;
      OP_AND, OP_OR, OP_XOR: op_latency = log_lat;
      default:               op_latency = 1;
    endcase
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    max4 = m;
  endfunction

endpackage

// File: rtl/ula_op_sequencer_if.sv
// Request/result bundle between the op sequencer and its requester / mux bank.
// Zero exists only when ULA_ZERO_FLAG_EN is defined.
interface ula_op_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             Start;
  logic [2:0]       OpCode;
  logic             DivisorZero;
  logic [WIDTH-1:0] Result_in;
  logic             Ready;
  logic [2:0]       Selector;
  logic [WIDTH-1:0] Result;
  logic             Done;
  logic             Error;
`ifdef ULA_ZERO_FLAG_EN
  logic             Zero;

  modport master (
    output Start, OpCode, DivisorZero, Result_in,
    input  Ready, Selector, Result, Done, Error, Zero
  );
  modport slave (
    input  Start, OpCode, DivisorZero, Result_in,
    output Ready, Selector, Result, Done, Error, Zero
  );
`else
  modport master (
    output Start, OpCode, DivisorZero, Result_in,
    input  Ready, Selector, Result, Done, Error
  );
  modport slave (
    input  Start, OpCode, DivisorZero, Result_in,
    output Ready, Selector, Result, Done, Error
  );
`endif
endinterface

// File: rtl/ula_op_sequencer_settle_counter.sv
// Settle-time down counter: load, decrement to zero and saturate there.
module ula_settle_counter #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ula_op_sequencer.sv
// ULA op sequencer: latches an opcode onto the mux-bank selector, waits its settle
// time, captures the result. Defining ULA_ZERO_FLAG_EN adds the registered Zero flag.
module ula_op_sequencer
  import ula_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 6,
  parameter int LOG_LAT = 1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  ula_op_sequencer_if.slave   bus
);

  localparam int MAX_LAT = max4(ADD_LAT, MUL_LAT, DIV_LAT, LOG_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_error, w_error_nxt;
  logic             r_done;
  logic             r_ready;
  logic             w_load, w_dec, w_cnt_zero;
  logic [CNT_W-1:0] w_load_val;
`ifdef ULA_ZERO_FLAG_EN
  logic             r_zero, w_zero_nxt;
`endif

  ula_settle_counter #(.CNT_W(CNT_W)) u_settle (
    .i_clk      (Clock),
    .i_rst_n    (Reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_result_nxt = r_result;
    w_error_nxt  = r_error;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_load_val   = CNT_W'(op_latency(bus.OpCode, ADD_LAT, MUL_LAT, DIV_LAT, LOG_LAT) - 1);
`ifdef ULA_ZERO_FLAG_EN
    w_zero_nxt   = r_zero;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.Start) begin
          w_sel_nxt = bus.OpCode;
          w_load    = 1'b1;
          if (bus.OpCode == OP_NOTUSE) begin
            w_state_nxt  = ST_DONE;
            w_result_nxt = '0;
            w_error_nxt  = 1'b1;
`ifdef ULA_ZERO_FLAG_EN
            w_zero_nxt   = 1'b0;
`endif
          end else if ((bus.OpCode == OP_DIV) && bus.DivisorZero) begin
            w_state_nxt  = ST_DONE;
            w_result_nxt = '1;
            w_error_nxt  = 1'b1;
`ifdef ULA_ZERO_FLAG_EN
            w_zero_nxt   = 1'b0;
`endif
          end else begin
            w_state_nxt = ST_EXEC;
            w_error_nxt = 1'b0;
          end
        end
      end
      // Mux bank is considered settled on the cycle the counter reads zero.
      ST_EXEC: begin
        if (w_cnt_zero) begin
          w_state_nxt  = ST_DONE;
          w_result_nxt = bus.Result_in;
`ifdef ULA_ZERO_FLAG_EN
          w_zero_nxt   = (bus.Result_in == '0);
`endif
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Done/Ready are registered from the next state so they line up with it.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_result <= '0;
      r_error  <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
`ifdef ULA_ZERO_FLAG_EN
      r_zero   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_result <= w_result_nxt;
      r_error  <= w_error_nxt;
      r_done   <= (w_state_nxt == ST_DONE);
      r_ready  <= (w_state_nxt == ST_IDLE);
`ifdef ULA_ZERO_FLAG_EN
      r_zero   <= w_zero_nxt;
`endif
    end
  end

  assign bus.Ready    = r_ready;
  assign bus.Selector = r_sel;
  assign bus.Result   = r_result;
  assign bus.Done     = r_done;
  assign bus.Error    = r_error;
`ifdef ULA_ZERO_FLAG_EN
  assign bus.Zero     = r_zero;
`endif

endmodule
